// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states,
// default bit period and the counter-width helper.
package fifo_uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam logic [2:0] LAST_BIT_IDX = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // A one-bit counter still needs one flop when the period is tiny.
    function automatic int cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, with a synchronous
// clear and a tick on the terminal count.
module uart_baud_cnt
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CW           = cnt_width(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_s;

    assign tick_s = (cnt_r == LAST_CNT);
    assign tick   = tick_s;
    assign cnt    = cnt_r;

    // Counter register; wraps to zero on the terminal count.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr || tick_s) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that pops bytes from an upstream FIFO (one-cycle read
// latency) and serialises them LSB first.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       en,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic [7:0] fifo_data,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    // tx_done is registered, so it is armed one count before the last stop cycle.
    localparam logic [CW-1:0] DONE_LEAD = CW'(CLKS_PER_BIT - 2);

    state_t        state_r;
    state_t        state_next_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_next_s;
    logic [2:0]    bit_idx_r;
    logic [2:0]    bit_idx_next_s;
    logic          tx_r;
    logic          tx_next_s;
    logic          tx_done_r;
    logic          tx_done_next_s;
    logic          busy_r;
    logic          ready_r;
    logic          pop_s;
    logic          cnt_clr_s;
    logic          tick_s;
    logic [CW-1:0] cnt_s;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CW           (CW)
    ) u_baud_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .clr   (cnt_clr_s),
        .cnt   (cnt_s),
        .tick  (tick_s)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        bit_idx_next_s = bit_idx_r;
        pop_s          = 1'b0;
        cnt_clr_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_clr_s = 1'b1;
                if (ready_r && en && !fifo_empty) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_clr_s      = 1'b1;
                shift_next_s   = fifo_data;
                bit_idx_next_s = 3'd0;
                state_next_s   = ST_START;
            end
            ST_START: begin
                if (tick_s) begin
                    bit_idx_next_s = 3'd0;
                    state_next_s   = ST_DATA;
                end else begin
                    state_next_s   = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_next_s = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == LAST_BIT_IDX) begin
                        state_next_s = ST_STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                cnt_clr_s    = 1'b1;
                state_next_s = ST_IDLE;
            end
        endcase

        case (state_next_s)
            ST_START: tx_next_s = 1'b0;
            ST_DATA:  tx_next_s = shift_next_s[0];
            default:  tx_next_s = 1'b1;
        endcase

        tx_done_next_s = (state_r == ST_STOP) && (cnt_s == DONE_LEAD);
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'h00;
            bit_idx_r <= 3'd0;
            tx_r      <= 1'b1;
            tx_done_r <= 1'b0;
            busy_r    <= 1'b0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            bit_idx_r <= bit_idx_next_s;
            tx_r      <= tx_next_s;
            tx_done_r <= tx_done_next_s;
            busy_r    <= (state_next_s != ST_IDLE);
            ready_r   <= 1'b1;
        end
    end

    // The pop cycle already commits a byte, so busy covers it too.
    assign fifo_rd = pop_s;
    assign busy    = busy_r | pop_s;
    assign tx      = tx_r;
    assign tx_done = tx_done_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with a 4-cycle bit period and
// a behavioural one-cycle-latency FIFO.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       en;
    logic       fifo_empty;
    logic       fifo_rd;
    logic [7:0] fifo_data;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int   n_assert = 0;
    int   n_fail   = 0;
    logic rd_prev  = 1'b0;

    logic [7:0] fifo_q[$];
    logic tx_log[$];
    logic busy_log[$];
    logic rd_log[$];
    logic done_log[$];

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic clear_logs();
        tx_log.delete();
        busy_log.delete();
        rd_log.delete();
        done_log.delete();
    endtask

    // One clock: outputs logged at the falling edge, FIFO answers after the rising edge.
    task automatic cycle();
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
        tx_log.push_back(tx);
        busy_log.push_back(busy);
        rd_log.push_back(fifo_rd);
        done_log.push_back(tx_done);
        rd_prev = fifo_rd;
        @(posedge clk);
        #1;
        if (rd_prev && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    endtask

    function automatic int count_ones(input logic lq[$], input int from);
        int n = 0;
        for (int i = from; i < lq.size(); i++) if (lq[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int first_val(input logic lq[$], input int from, input logic v);
        for (int i = from; i < lq.size(); i++) if (lq[i] === v) return i;
        return -1;
    endfunction

    task automatic test_reset();
        fifo_q.push_back(8'hAA);
        en = 1'b1;
        clr_n = 1'b0;
        fifo_data = 8'h00;
        clear_logs();
        repeat (3) cycle();
        n_assert++; if (tx_log[2] !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx_log[2]); end
        n_assert++; if (busy_log[2] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_log[2]); end
        n_assert++; if (count_ones(rd_log, 0) != 0) begin n_fail++; $display("FAIL reset_rd: got %0d pulses expected 0", count_ones(rd_log, 0)); end
        n_assert++; if (done_log[2] !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_log[2]); end
        en = 1'b0;
        clr_n = 1'b1;
        clear_logs();
        repeat (4) cycle();
        n_assert++; if (count_ones(rd_log, 0) != 0) begin n_fail++; $display("FAIL reset_en_low_rd: got %0d pulses expected 0", count_ones(rd_log, 0)); end
        fifo_q.delete();
        repeat (2) cycle();
    endtask

    task automatic test_single_byte();
        logic [9:0] exp_frame;
        int s;
        int p;
        exp_frame = 10'b1001101010;
        clear_logs();
        fifo_q.push_back(8'h35);
        en = 1'b1;
        repeat (60) cycle();
        en = 1'b0;
        s = first_val(tx_log, 0, 1'b0);
        p = first_val(rd_log, 0, 1'b1);
        n_assert++; if (count_ones(rd_log, 0) != 1) begin n_fail++; $display("FAIL single_rd_count: got %0d expected 1", count_ones(rd_log, 0)); end
        n_assert++;
        if (s < 0 || p < 0 || s + 10 * CPB > tx_log.size()) begin
            n_fail++; $display("FAIL single_window: start %0d pop %0d expected a full frame", s, p);
        end else begin
            if (s != p + 2) begin n_fail++; $display("FAIL single_latency: start at %0d expected %0d", s, p + 2); end
            for (int b = 0; b < 10; b++) begin
                logic ok;
                ok = 1'b1;
                for (int k = 0; k < CPB; k++) if (tx_log[s + CPB * b + k] !== exp_frame[b]) ok = 1'b0;
                n_assert++;
                if (!ok) begin n_fail++; $display("FAIL single_bit%0d: tx not steady, expected %b", b, exp_frame[b]); end
            end
            n_assert++;
            if (first_val(done_log, 0, 1'b1) != s + 10 * CPB - 1) begin
                n_fail++; $display("FAIL single_done_pos: got %0d expected %0d", first_val(done_log, 0, 1'b1), s + 10 * CPB - 1);
            end
        end
        n_assert++; if (count_ones(done_log, 0) != 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", count_ones(done_log, 0)); end
        n_assert++; if (count_ones(busy_log, 0) != 42) begin n_fail++; $display("FAIL single_busy_len: got %0d expected 42", count_ones(busy_log, 0)); end
        n_assert++; if (tx_log[59] !== 1'b1 || busy_log[59] !== 1'b0) begin n_fail++; $display("FAIL single_idle_after: tx %b busy %b expected 1 0", tx_log[59], busy_log[59]); end
    endtask

    task automatic test_empty_fifo();
        clear_logs();
        en = 1'b1;
        repeat (100) cycle();
        en = 1'b0;
        n_assert++; if (count_ones(rd_log, 0) != 0) begin n_fail++; $display("FAIL empty_rd: got %0d pulses expected 0", count_ones(rd_log, 0)); end
        n_assert++; if (count_ones(tx_log, 0) != 100) begin n_fail++; $display("FAIL empty_tx: got %0d high cycles expected 100", count_ones(tx_log, 0)); end
        n_assert++; if (count_ones(busy_log, 0) != 0) begin n_fail++; $display("FAIL empty_busy: got %0d busy cycles expected 0", count_ones(busy_log, 0)); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_a;
        logic [9:0] exp_b;
        int s1;
        int s2;
        exp_a = 10'b1000000000;
        exp_b = 10'b1111111110;
        clear_logs();
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        en = 1'b1;
        repeat (100) cycle();
        en = 1'b0;
        s1 = first_val(tx_log, 0, 1'b0);
        s2 = (s1 < 0) ? -1 : first_val(tx_log, s1 + 10 * CPB, 1'b0);
        n_assert++; if (count_ones(rd_log, 0) != 2) begin n_fail++; $display("FAIL b2b_rd_count: got %0d expected 2", count_ones(rd_log, 0)); end
        n_assert++; if (count_ones(done_log, 0) != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", count_ones(done_log, 0)); end
        n_assert++;
        if (s1 < 0 || s2 < 0 || s2 + 10 * CPB > tx_log.size()) begin
            n_fail++; $display("FAIL b2b_window: starts %0d %0d expected two full frames", s1, s2);
        end else begin
            if (s2 - s1 != 10 * CPB + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", s2 - s1, 10 * CPB + 2); end
            n_assert++;
            if (tx_log[s1 + 40] !== 1'b1 || tx_log[s1 + 41] !== 1'b1) begin
                n_fail++; $display("FAIL b2b_gap_tx: got %b%b expected 11", tx_log[s1 + 40], tx_log[s1 + 41]);
            end
            for (int b = 0; b < 10; b++) begin
                logic ok;
                ok = 1'b1;
                for (int k = 0; k < CPB; k++) begin
                    if (tx_log[s1 + CPB * b + k] !== exp_a[b]) ok = 1'b0;
                    if (tx_log[s2 + CPB * b + k] !== exp_b[b]) ok = 1'b0;
                end
                n_assert++;
                if (!ok) begin n_fail++; $display("FAIL b2b_bit%0d: tx not steady, expected %b then %b", b, exp_a[b], exp_b[b]); end
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [9:0] exp_frame;
        int s;
        exp_frame = 10'b1101001010;
        clear_logs();
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h5A);
        en = 1'b1;
        repeat (14) cycle();
        en = 1'b0;
        repeat (60) cycle();
        s = first_val(tx_log, 0, 1'b0);
        n_assert++; if (count_ones(rd_log, 0) != 1) begin n_fail++; $display("FAIL endrop_rd_count: got %0d expected 1", count_ones(rd_log, 0)); end
        n_assert++; if (fifo_q.size() != 1) begin n_fail++; $display("FAIL endrop_fifo_left: got %0d expected 1", fifo_q.size()); end
        n_assert++; if (count_ones(done_log, 0) != 1) begin n_fail++; $display("FAIL endrop_done_count: got %0d expected 1", count_ones(done_log, 0)); end
        n_assert++;
        if (s < 0 || s + 10 * CPB > tx_log.size()) begin
            n_fail++; $display("FAIL endrop_window: start %0d expected a full frame", s);
        end else begin
            for (int b = 0; b < 10; b++) begin
                logic ok;
                ok = 1'b1;
                for (int k = 0; k < CPB; k++) if (tx_log[s + CPB * b + k] !== exp_frame[b]) ok = 1'b0;
                n_assert++;
                if (!ok) begin n_fail++; $display("FAIL endrop_bit%0d: tx not steady, expected %b", b, exp_frame[b]); end
            end
        end
        fifo_q.delete();
        repeat (2) cycle();
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp_frame;
        int s;
        int r;
        int s2;
        int guard;
        exp_frame = 10'b1110000110;
        clear_logs();
        fifo_q.push_back(8'h35);
        fifo_q.push_back(8'hC3);
        en = 1'b1;
        repeat (6) cycle();
        s = first_val(tx_log, 0, 1'b0);
        n_assert++;
        if (s < 0) begin
            n_fail++; $display("FAIL rstmid_start: no start bit in %0d cycles", tx_log.size());
            s = 0;
        end
        guard = 0;
        while (tx_log.size() < s + CPB * 4 + 2 && guard < 60) begin
            cycle();
            guard++;
        end
        clr_n = 1'b0;
        cycle();
        r = tx_log.size() - 1;
        n_assert++; if (tx_log[r] !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b expected 1", tx_log[r]); end
        n_assert++; if (busy_log[r] !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy_log[r]); end
        repeat (2) cycle();
        clr_n = 1'b1;
        r = tx_log.size();
        repeat (60) cycle();
        en = 1'b0;
        n_assert++;
        if (rd_log[r] !== 1'b0 || rd_log[r + 1] !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pop_delay: got %b%b expected 01", rd_log[r], rd_log[r + 1]);
        end
        s2 = first_val(tx_log, r, 1'b0);
        n_assert++;
        if (s2 != r + 3 || s2 + 10 * CPB > tx_log.size()) begin
            n_fail++; $display("FAIL rstmid_restart: start at %0d expected %0d", s2, r + 3);
        end else begin
            for (int b = 0; b < 10; b++) begin
                logic ok;
                ok = 1'b1;
                for (int k = 0; k < CPB; k++) if (tx_log[s2 + CPB * b + k] !== exp_frame[b]) ok = 1'b0;
                n_assert++;
                if (!ok) begin n_fail++; $display("FAIL rstmid_bit%0d: tx not steady, expected %b", b, exp_frame[b]); end
            end
        end
        n_assert++; if (count_ones(done_log, r) != 1) begin n_fail++; $display("FAIL rstmid_done_count: got %0d expected 1", count_ones(done_log, r)); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_empty_fifo();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port clr_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  level; permits starting a new FIFO pop when high.
REQ-006 SHALL have port fifo_empty  input  1  high when the upstream FIFO holds no entries.
REQ-007 SHALL have port fifo_rd  output  1  single-cycle read strobe to the upstream FIFO.
REQ-008 SHALL have port fifo_data  input  8  FIFO read data, valid the cycle after fifo_rd.
REQ-009 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port tx_done  output  1  single-cycle pulse at the end of each stop bit.

Function
REQ-012 SHALL implement states IDLE, WAIT, START, DATA, STOP.
REQ-013 IDLE: when en=1 and fifo_empty=0, SHALL assert fifo_rd for exactly one cycle and go to WAIT; otherwise stay, fifo_rd=0.
REQ-014 WAIT: SHALL capture fifo_data into an 8-bit shift register, clear the baud counter, and go to START after exactly one cycle.
REQ-015 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-016 DATA: tx=shift[0], LSB first; each bit held CLKS_PER_BIT cycles; after bit 7 go to STOP.
REQ-017 STOP: tx=1 for CLKS_PER_BIT cycles; tx_done=1 on the last cycle; then IDLE.
REQ-018 Frame length from START entry to STOP exit SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-019 Back-to-back bytes: the gap from STOP exit to the next START entry SHALL be exactly 2 cycles (IDLE pop, WAIT), with tx=1 throughout.
REQ-020 en or fifo_empty changing mid-frame SHALL NOT affect the current frame; they are sampled only in IDLE.
REQ-021 fifo_rd SHALL never assert outside IDLE, nor while fifo_empty=1.
REQ-022 tx SHALL be driven from a register (glitch-free).
REQ-023 Baud counter width SHALL be $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.

Reset
REQ-024 On clr_n=0, asynchronously: state=IDLE, tx=1, fifo_rd=0, busy=0, tx_done=0, counters and shift register 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; the popped byte is lost; after release, operation resumes from IDLE.

Structure
REQ-026 SHALL place the state enum and the default CLKS_PER_BIT constant in shared package fifo_uart_pkg.
REQ-027 SHALL factor the bit-period counter into one sub-module, uart_baud_cnt (clear input, tick output on terminal count).

Verification (CLKS_PER_BIT=4)
REQ-028 Single byte: FIFO holds 0x35, en=1 -> one fifo_rd pulse; tx = 0,1,0,1,0,1,1,0,0,1, each 4 cycles; one tx_done pulse; busy=1 for 42 cycles.
REQ-029 Empty FIFO: fifo_empty=1, en=1 for 100 cycles -> fifo_rd=0, tx=1, busy=0 throughout.
REQ-030 Back-to-back: FIFO holds 0x00 then 0xFF -> two frames; exactly 2 tx-high cycles between the first stop bit and the second start bit; two fifo_rd pulses.
REQ-031 Enable drop: en falls during DATA of 0xA5 -> frame completes correctly; no further fifo_rd while en=0, even with fifo_empty=0.
REQ-032 Reset mid-frame: clr_n low during bit 3 -> tx=1, busy=0 immediately; after release with FIFO non-empty, next pop after 1 cycle; a clean frame follows.
